// File: rtl/dcu_pkg.sv
// Shared definitions for the OFDM TX data-combine unit: sizes, FSM states,
// sample payload layout and the payload-length helper.
package dcu_pkg;

    localparam int unsigned DW         = 12;
    localparam int unsigned SIG_LEN    = 480;
    localparam int unsigned SYM_LEN    = 480;
    localparam int unsigned NUM_W      = 4;
    localparam int unsigned FIFO_DEPTH = 1024;

    localparam int unsigned SIG_AW     = $clog2(SIG_LEN);
    localparam int unsigned SIG_CNT_W  = $clog2(SIG_LEN + 1);
    localparam int unsigned MAX_PLD    = ((1 << NUM_W) - 1) * SYM_LEN;
    localparam int unsigned OUT_W      = $clog2(MAX_PLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIG_OUT = 2'd1,
        ST_PLD_OUT = 2'd2,
        ST_DONE    = 2'd3
    } dcu_state_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } dcu_sample_t;

    // Number of payload samples making up a frame of num symbols.
    function automatic logic [OUT_W-1:0] pld_total(input logic [NUM_W-1:0] num);
        return OUT_W'(num) * OUT_W'(SYM_LEN);
    endfunction

endpackage

// File: rtl/dcu_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          synchronous clear (pointers only)
//   wr_en/wr_data push; ignored while full
//   rd_en        pop; ignored while empty
//   rd_data_c    head-of-queue word (combinational)
//   full_c/empty_c status flags (combinational)
module dcu_sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_c;
    logic             pop_c;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_c    = wr_en && !full_c;
    assign pop_c     = rd_en && !empty_c;
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dcu_combiner.sv
// OFDM TX data-combine unit: emits one SIGNAL block followed by the frame's
// payload symbols as a single ordered stream, flagging the final sample.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   new_frame            synchronous frame restart (same effect as reset)
//   signal_di_*          SIGNAL-field sample input (re/im/vld)
//   payload_di_*         payload sample input (re/im/num/sym_end/vld)
//   do_re/do_im/do_vld   combined output sample, zero while not valid
//   do_last              marks the final sample of the frame
module dcu_combiner
    import dcu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_frame,
    input  logic [DW-1:0]    signal_di_re,
    input  logic [DW-1:0]    signal_di_im,
    input  logic             signal_di_vld,
    input  logic [DW-1:0]    payload_di_re,
    input  logic [DW-1:0]    payload_di_im,
    input  logic [NUM_W-1:0] payload_di_num,
    input  logic             payload_di_sym_end,
    input  logic             payload_di_vld,
    output logic [DW-1:0]    do_re,
    output logic [DW-1:0]    do_im,
    output logic             do_last,
    output logic             do_vld
);

    dcu_state_t           state;
    dcu_sample_t          sig_buf [SIG_LEN];
    dcu_sample_t          sig_wr_data_c;
    dcu_sample_t          pld_wr_data_c;
    dcu_sample_t          fifo_rd_data_c;
    logic [SIG_CNT_W-1:0] sig_wr_cnt;
    logic [SIG_AW-1:0]    sig_rd_ptr;
    logic [NUM_W-1:0]     pld_num;
    logic                 pld_num_seen;
    logic [OUT_W-1:0]     pld_out_cnt;

    logic                 clr_c;
    logic                 sig_wr_en_c;
    logic                 sig_full_c;
    logic                 sig_emit_c;
    logic                 sig_rd_last_c;
    logic [NUM_W-1:0]     eff_num_c;
    logic [OUT_W-1:0]     pld_total_c;
    logic                 pld_rd_last_c;
    logic                 fifo_pop_c;
    logic                 fifo_full_c;
    logic                 fifo_empty_c;
    logic                 status_unused_c;

    assign clr_c         = !rst_n || new_frame;
    assign sig_full_c    = (sig_wr_cnt == SIG_CNT_W'(SIG_LEN));
    assign sig_wr_en_c   = signal_di_vld && !clr_c && !sig_full_c;
    assign sig_emit_c    = (state == ST_SIG_OUT) || ((state == ST_IDLE) && sig_full_c);
    assign sig_rd_last_c = (sig_rd_ptr == SIG_AW'(SIG_LEN - 1));

    // Symbol count is taken from the first payload sample; before that the
    // live input is used so a payload-less frame (num=0) can still terminate.
    assign eff_num_c     = pld_num_seen ? pld_num : payload_di_num;
    assign pld_total_c   = pld_total(eff_num_c);
    assign pld_rd_last_c = ((pld_out_cnt + OUT_W'(1)) == pld_total_c);
    assign fifo_pop_c    = (state == ST_PLD_OUT) && !fifo_empty_c;

    // Symbol boundaries are implied by the sample count; sym_end and the
    // FIFO full flag carry no information this block needs.
    assign status_unused_c = payload_di_sym_end ^ fifo_full_c;

    always_comb begin
        sig_wr_data_c    = '0;
        sig_wr_data_c.re = signal_di_re;
        sig_wr_data_c.im = signal_di_im;
        pld_wr_data_c    = '0;
        pld_wr_data_c.re = payload_di_re;
        pld_wr_data_c.im = payload_di_im;
    end

    // SIGNAL buffer write port; extra samples beyond SIG_LEN are ignored.
    always_ff @(posedge clk) begin
        if (sig_wr_en_c) sig_buf[sig_wr_cnt[SIG_AW-1:0]] <= sig_wr_data_c;
    end

    // Payload is queued until the SIGNAL block has been emitted.
    dcu_sync_fifo #(
        .WIDTH ($bits(dcu_sample_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pld_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (new_frame),
        .wr_en     (payload_di_vld),
        .wr_data   (pld_wr_data_c),
        .rd_en     (fifo_pop_c),
        .rd_data_c (fifo_rd_data_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Frame sequencer with registered outputs. The SIGNAL read is folded into
    // the output register so the first sample leaves one cycle after the
    // buffer fills.
    always_ff @(posedge clk) begin
        if (clr_c) begin
            state        <= ST_IDLE;
            sig_wr_cnt   <= '0;
            sig_rd_ptr   <= '0;
            pld_num      <= '0;
            pld_num_seen <= 1'b0;
            pld_out_cnt  <= '0;
            do_re        <= '0;
            do_im        <= '0;
            do_last      <= 1'b0;
            do_vld       <= 1'b0;
        end else begin
            do_re   <= '0;
            do_im   <= '0;
            do_last <= 1'b0;
            do_vld  <= 1'b0;

            if (sig_wr_en_c) sig_wr_cnt <= sig_wr_cnt + SIG_CNT_W'(1);

            if (payload_di_vld && !pld_num_seen) begin
                pld_num      <= payload_di_num;
                pld_num_seen <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_SIG_OUT: begin
                    if (sig_emit_c) begin
                        do_vld     <= 1'b1;
                        do_re      <= sig_buf[sig_rd_ptr].re;
                        do_im      <= sig_buf[sig_rd_ptr].im;
                        sig_rd_ptr <= sig_rd_ptr + SIG_AW'(1);
                        if (!sig_rd_last_c) begin
                            state <= ST_SIG_OUT;
                        end else if (eff_num_c == '0) begin
                            do_last <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_PLD_OUT;
                        end
                    end
                end
                ST_PLD_OUT: begin
                    if (fifo_pop_c) begin
                        do_vld      <= 1'b1;
                        do_re       <= fifo_rd_data_c.re;
                        do_im       <= fifo_rd_data_c.im;
                        pld_out_cnt <= pld_out_cnt + OUT_W'(1);
                        if (pld_rd_last_c) begin
                            do_last <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcu_combiner.sv
// Bench for dcu_combiner: random/ramp frames against a sequence model
// (SIGNAL samples, then num*SYM_LEN payload samples, last flag on the end).
module tb_dcu_combiner;
    import dcu_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             new_frame;
    logic [DW-1:0]    signal_di_re, signal_di_im;
    logic             signal_di_vld;
    logic [DW-1:0]    payload_di_re, payload_di_im;
    logic [NUM_W-1:0] payload_di_num;
    logic             payload_di_sym_end;
    logic             payload_di_vld;
    logic [DW-1:0]    do_re, do_im;
    logic             do_last, do_vld;

    dcu_combiner dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .new_frame          (new_frame),
        .signal_di_re       (signal_di_re),
        .signal_di_im       (signal_di_im),
        .signal_di_vld      (signal_di_vld),
        .payload_di_re      (payload_di_re),
        .payload_di_im      (payload_di_im),
        .payload_di_num     (payload_di_num),
        .payload_di_sym_end (payload_di_sym_end),
        .payload_di_vld     (payload_di_vld),
        .do_re              (do_re),
        .do_im              (do_im),
        .do_last            (do_last),
        .do_vld             (do_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*DW-1:0] d;
        logic            last;
        longint          t;
    } obs_t;

    int              n_err = 0;
    int              n_chk = 0;
    longint          cyc = 0;
    longint          last_sig_t = 0;
    int              zero_viol = 0;
    logic [2*DW-1:0] sig_q[$];
    logic [2*DW-1:0] pld_q[$];
    logic [2*DW-1:0] exp_q[$];
    obs_t            obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        if (do_vld === 1'b1)
            obs_q.push_back('{d: {do_re, do_im}, last: do_last, t: cyc});
        else if (do_last !== 1'b0 || do_re !== '0 || do_im !== '0)
            zero_viol++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic gen_sig(input int n, input int base);
        sig_q.delete();
        for (int i = 0; i < n; i++)
            sig_q.push_back(base < 0 ? {DW'($urandom), DW'($urandom)} : {DW'(base + i), DW'(base + i)});
    endtask

    task automatic gen_pld(input int n, input int base);
        pld_q.delete();
        for (int i = 0; i < n; i++)
            pld_q.push_back(base < 0 ? {DW'($urandom), DW'($urandom)} : {DW'(base + i), DW'(base + i)});
    endtask

    // Model: SIGNAL block in order, then exactly num symbols of payload.
    task automatic build_expected(input int num);
        exp_q.delete();
        for (int i = 0; i < int'(SIG_LEN); i++) exp_q.push_back(sig_q[i]);
        for (int i = 0; i < num * int'(SYM_LEN); i++) exp_q.push_back(pld_q[i]);
    endtask

    task automatic drive_sig(input int lo, input int hi);
        for (int i = 0; i < sig_q.size(); i++) begin
            int g = $urandom_range(hi, lo);
            repeat (g) begin @(posedge clk); #1; end
            {signal_di_re, signal_di_im} = sig_q[i];
            signal_di_vld = 1'b1;
            last_sig_t = cyc + 1;
            @(posedge clk); #1;
            signal_di_vld = 1'b0;
            {signal_di_re, signal_di_im} = {DW'($urandom), DW'($urandom)};
        end
    endtask

    task automatic drive_pld(input int lo, input int hi);
        for (int i = 0; i < pld_q.size(); i++) begin
            int g = $urandom_range(hi, lo);
            repeat (g) begin @(posedge clk); #1; end
            {payload_di_re, payload_di_im} = pld_q[i];
            payload_di_sym_end = ((i + 1) % int'(SYM_LEN)) == 0;
            payload_di_vld = 1'b1;
            @(posedge clk); #1;
            payload_di_vld = 1'b0;
            payload_di_sym_end = 1'b0;
            {payload_di_re, payload_di_im} = {DW'($urandom), DW'($urandom)};
        end
    endtask

    task automatic new_frame_pulse();
        @(posedge clk); #1;
        new_frame = 1'b1;
        @(posedge clk); #1;
        new_frame = 1'b0;
        obs_q.delete();
        zero_viol = 0;
    endtask

    task automatic wait_out(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (obs_q.size() >= n) begin to = 1'b0; break; end
            @(posedge clk);
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    // Summarises the observed stream against exp_q (metrics only).
    task automatic score(output int n_out, output int mis_idx, output int n_last, output int last_pos);
        n_out = obs_q.size(); mis_idx = -1; n_last = 0; last_pos = -1;
        for (int i = 0; i < n_out; i++) begin
            if (mis_idx < 0 && (i >= exp_q.size() || obs_q[i].d !== exp_q[i])) mis_idx = i;
            if (obs_q[i].last === 1'b1) begin n_last++; last_pos = i; end
        end
        if (mis_idx < 0 && n_out < exp_q.size()) mis_idx = n_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (do_vld !== 1'b0) begin n_err++; $display("FAIL reset do_vld: got %b want 0", do_vld); end
        n_chk++; if (do_last !== 1'b0) begin n_err++; $display("FAIL reset do_last: got %b want 0", do_last); end
        n_chk++; if (do_re !== '0) begin n_err++; $display("FAIL reset do_re: got %0h want 0", do_re); end
        n_chk++; if (do_im !== '0) begin n_err++; $display("FAIL reset do_im: got %0h want 0", do_im); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        bit to; int n_out, mis, n_last, lpos;
        payload_di_num = 4'd1;
        gen_sig(SIG_LEN, -1); gen_pld(SYM_LEN, -1);
        fork drive_sig(0, 0); drive_pld(0, 0); join
        to = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (obs_q.size() >= 50) begin to = 1'b0; break; end
            @(posedge clk);
        end
        n_chk++; if (to) begin n_err++; $display("FAIL midreset wait: got %0d outputs want 50", obs_q.size()); end
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({do_vld, do_last} !== 2'b00) begin n_err++; $display("FAIL midreset flags: got vld=%b last=%b want 0 0", do_vld, do_last); end
        n_chk++; if ({do_re, do_im} !== '0) begin n_err++; $display("FAIL midreset data: got %0h want 0", {do_re, do_im}); end
        rst_n = 1'b1;
        new_frame_pulse();
        payload_di_num = 4'd1;
        gen_sig(SIG_LEN, -1); gen_pld(SYM_LEN, -1); build_expected(1);
        fork drive_sig(0, 2); drive_pld(0, 3); join
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        n_chk++; if (to || n_out != exp_q.size()) begin n_err++; $display("FAIL midreset count: got %0d want %0d", n_out, exp_q.size()); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL midreset order: first bad index %0d want -1", mis); end
        n_chk++; if (n_last != 1 || lpos != exp_q.size() - 1) begin n_err++; $display("FAIL midreset last: got %0d flags at %0d want 1 at %0d", n_last, lpos, exp_q.size() - 1); end
    endtask

    task automatic test_rates();
        bit to; int n_out, mis, n_last, lpos;
        new_frame_pulse();
        payload_di_num = 4'd5;
        gen_sig(SIG_LEN, -1); gen_pld(5 * SYM_LEN, -1); build_expected(5);
        fork drive_sig(1, 1); drive_pld(3, 3); join
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        n_chk++; if (to || n_out != 2880) begin n_err++; $display("FAIL rates count: got %0d want 2880", n_out); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL rates order: first bad index %0d want -1", mis); end
        n_chk++; if (n_last != 1 || lpos != 2879) begin n_err++; $display("FAIL rates last: got %0d flags at %0d want 1 at 2879", n_last, lpos); end
        n_chk++; if (zero_viol != 0) begin n_err++; $display("FAIL rates idle_zero: got %0d violations want 0", zero_viol); end
    endtask

    task automatic test_ramp();
        bit to; int n_out, mis, n_last, lpos; longint lat;
        new_frame_pulse();
        payload_di_num = 4'd1;
        gen_sig(SIG_LEN, 0); gen_pld(SYM_LEN, 1000); build_expected(1);
        fork drive_sig(0, 2); drive_pld(0, 2); join
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        lat = (n_out > 0) ? obs_q[0].t - last_sig_t : -1;
        n_chk++; if (to || n_out != 960) begin n_err++; $display("FAIL ramp count: got %0d want 960", n_out); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL ramp order: first bad index %0d want -1", mis); end
        n_chk++; if (lpos < 0 || obs_q[lpos].d !== {DW'(1479), DW'(1479)} || n_last != 1) begin
            n_err++; $display("FAIL ramp last_value: got %0d flags last at %0d want 1 flag on 1479", n_last, lpos); end
        n_chk++; if (lat < 1 || lat > 2) begin n_err++; $display("FAIL ramp latency: got %0d cycles want 1..2", lat); end
    endtask

    task automatic test_payload_first();
        bit to; int n_out, mis, n_last, lpos; longint gmax;
        new_frame_pulse();
        payload_di_num = 4'd1;
        gen_sig(SIG_LEN, -1); gen_pld(SYM_LEN, -1); build_expected(1);
        drive_pld(0, 0);
        repeat (20) @(posedge clk); #1;
        drive_sig(0, 1);
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        gmax = 0;
        if (n_out >= 960)
            for (int i = 1; i < 960; i++)
                if (i != 480 && obs_q[i].t - obs_q[i-1].t > gmax) gmax = obs_q[i].t - obs_q[i-1].t;
        n_chk++; if (to || n_out != 960) begin n_err++; $display("FAIL pfirst count: got %0d want 960", n_out); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL pfirst order: first bad index %0d want -1", mis); end
        n_chk++; if (gmax != 1) begin n_err++; $display("FAIL pfirst contiguous: got max step %0d want 1", gmax); end
        n_chk++; if (n_last != 1 || lpos != 959) begin n_err++; $display("FAIL pfirst last: got %0d flags at %0d want 1 at 959", n_last, lpos); end
    endtask

    task automatic test_new_frame();
        bit to; int n_out, mis, n_last, lpos;
        new_frame_pulse();
        payload_di_num = 4'd3;
        gen_sig(100, -1); gen_pld(60, -1);
        fork drive_sig(0, 1); drive_pld(0, 1); join
        new_frame_pulse();
        payload_di_num = 4'd2;
        gen_sig(SIG_LEN, -1); gen_pld(2 * SYM_LEN, -1); build_expected(2);
        fork drive_sig(0, 3); drive_pld(0, 3); join
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        n_chk++; if (to || n_out != 1440) begin n_err++; $display("FAIL newframe count: got %0d want 1440", n_out); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL newframe order: first bad index %0d want -1", mis); end
        n_chk++; if (n_last != 1 || lpos != 1439) begin n_err++; $display("FAIL newframe last: got %0d flags at %0d want 1 at 1439", n_last, lpos); end
    endtask

    task automatic test_stall();
        bit to; int n_out, mis, n_last, lpos, gaps;
        new_frame_pulse();
        payload_di_num = 4'd2;
        gen_sig(SIG_LEN, -1); gen_pld(2 * SYM_LEN, -1); build_expected(2);
        fork drive_sig(0, 0); drive_pld(0, 12); join
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        gaps = 0;
        for (int i = 481; i < n_out; i++) if (obs_q[i].t - obs_q[i-1].t > 1) gaps++;
        n_chk++; if (to || n_out != 1440) begin n_err++; $display("FAIL stall count: got %0d want 1440", n_out); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL stall order: first bad index %0d want -1", mis); end
        n_chk++; if (n_last != 1 || lpos != 1439) begin n_err++; $display("FAIL stall last: got %0d flags at %0d want 1 at 1439", n_last, lpos); end
        n_chk++; if (gaps == 0) begin n_err++; $display("FAIL stall gaps: got %0d gaps want >0", gaps); end
        n_chk++; if (zero_viol != 0) begin n_err++; $display("FAIL stall idle_zero: got %0d violations want 0", zero_viol); end
    endtask

    task automatic test_num_zero();
        bit to; int n_out, mis, n_last, lpos;
        new_frame_pulse();
        payload_di_num = 4'd0;
        gen_sig(SIG_LEN, -1); pld_q.delete(); build_expected(0);
        drive_sig(0, 1);
        wait_out(exp_q.size(), 3000, to);
        score(n_out, mis, n_last, lpos);
        n_chk++; if (to || n_out != 480) begin n_err++; $display("FAIL numzero count: got %0d want 480", n_out); end
        n_chk++; if (mis != -1) begin n_err++; $display("FAIL numzero order: first bad index %0d want -1", mis); end
        n_chk++; if (n_last != 1 || lpos != 479) begin n_err++; $display("FAIL numzero last: got %0d flags at %0d want 1 at 479", n_last, lpos); end
    endtask

    initial begin
        rst_n = 1'b0; new_frame = 1'b0;
        signal_di_re = '0; signal_di_im = '0; signal_di_vld = 1'b0;
        payload_di_re = '0; payload_di_im = '0; payload_di_num = '0;
        payload_di_sym_end = 1'b0; payload_di_vld = 1'b0;
        #1;
        test_reset();
        test_mid_reset();
        test_rates();
        test_ramp();
        test_payload_first();
        test_new_frame();
        test_stall();
        test_num_zero();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
